bfp_rescale: RTL and testbench

Block-floating-point rescaler between FFT butterfly stages. Takes LANES complex samples per beat and applies one frame-wide shift, derived from the stage's leading-sign count, with optional rounding and saturation. It counts beats to delimit frames, tracks the accumulated block exponent, and flags overflow per frame. The block is a 2-stage valid/ready pipeline that replaces the fixed single-cycle shifter in the stage-to-stage datapath.

---
 rtl/bfp_pkg.sv | 27 ++
 rtl/bfp_lane_scale.sv | 63 ++++++
 rtl/bfp_rescale.sv | 157 +++++++++++++++
 tb/tb_bfp_rescale.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bfp_pkg.sv
// rtl/bfp_pkg.sv - shared types and helpers for block-floating-point stage blocks
package bfp_pkg;

   localparam int BFP_LANES   = 16;
   localparam int BFP_O_WIDTH = 11;

   typedef struct packed {
      logic [BFP_LANES-1:0][BFP_O_WIDTH-1:0] re;
      logic [BFP_LANES-1:0][BFP_O_WIDTH-1:0] im;
   } cplx_beat_t;

   // Wide enough that the largest left shift (all-ones shift_cnt) loses no bits.
   function automatic int int_width(input int i_w, input int cnt_w, input int length);
      return i_w + (1 << cnt_w) - 1 - length;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int o_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (o_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (o_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/bfp_lane_scale.sv
// rtl/bfp_lane_scale.sv - per-lane shift/round (pre-S1) and range check (pre-S2)
module bfp_lane_scale
   import bfp_pkg::*;
#(
   parameter int I_WIDTH   = 23,
   parameter int O_WIDTH   = 11,
   parameter int CNT_WIDTH = 5,
   parameter int LENGTH    = 12,
   parameter int W         = int_width(I_WIDTH, CNT_WIDTH, LENGTH)
)(
   input  logic                        rnd_en,
   input  logic [CNT_WIDTH-1:0]        shift_cnt,
   input  logic signed [I_WIDTH-1:0]   din_re,
   input  logic signed [I_WIDTH-1:0]   din_im,
   output logic signed [W-1:0]         wide_re,
   output logic signed [W-1:0]         wide_im,
   input  logic                        sat_en,
   input  logic signed [W-1:0]         s1_re,
   input  logic signed [W-1:0]         s1_im,
   output logic signed [O_WIDTH-1:0]   dout_re,
   output logic signed [O_WIDTH-1:0]   dout_im,
   output logic                        ovf
);

   localparam logic [CNT_WIDTH-1:0] LEN = CNT_WIDTH'(LENGTH);

   logic                 left;
   logic [CNT_WIDTH-1:0] amt;
   logic signed [W-1:0]  bias;
   logic signed [W-1:0]  ext_re;
   logic signed [W-1:0]  ext_im;

   always_comb begin
      left = shift_cnt > LEN;
      amt  = left ? shift_cnt - LEN : LEN - shift_cnt;
      bias = '0;
      if (!left && rnd_en && amt != '0)
         bias = W'(1) << (amt - CNT_WIDTH'(1));
   end

   assign ext_re  = {{(W-I_WIDTH){din_re[I_WIDTH-1]}}, din_re};
   assign ext_im  = {{(W-I_WIDTH){din_im[I_WIDTH-1]}}, din_im};
   assign wide_re = left ? (ext_re <<< amt) : ((ext_re + bias) >>> amt);
   assign wide_im = left ? (ext_im <<< amt) : ((ext_im + bias) >>> amt);

   logic signed [63:0] x_re;
   logic signed [63:0] x_im;
   logic signed [63:0] c_re;
   logic signed [63:0] c_im;

   always_comb begin
      x_re = {{(64-W){s1_re[W-1]}}, s1_re};
      x_im = {{(64-W){s1_im[W-1]}}, s1_im};
      c_re = saturate(x_re, O_WIDTH);
      c_im = saturate(x_im, O_WIDTH);
   end

   // A value is out of range exactly when clamping would change it.
   assign dout_re = sat_en ? c_re[O_WIDTH-1:0] : x_re[O_WIDTH-1:0];
   assign dout_im = sat_en ? c_im[O_WIDTH-1:0] : x_im[O_WIDTH-1:0];
   assign ovf     = (c_re != x_re) | (c_im != x_im);

endmodule

// File: rtl/bfp_rescale.sv
// rtl/bfp_rescale.sv - two-stage block-floating-point rescaler between FFT stages
module bfp_rescale
   import bfp_pkg::*;
#(
   parameter int LANES     = 16,
   parameter int I_WIDTH   = 23,
   parameter int O_WIDTH   = 11,
   parameter int CNT_WIDTH = 5,
   parameter int LENGTH    = 12,
   parameter int EXP_WIDTH = 6,
   parameter int BEATS     = 32
)(
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*I_WIDTH-1:0]    din_re,
   input  logic [LANES*I_WIDTH-1:0]    din_im,
   input  logic [CNT_WIDTH-1:0]        shift_cnt,
   input  logic signed [EXP_WIDTH-1:0] exp_in,
   input  logic                        rnd_en,
   input  logic                        sat_en,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*O_WIDTH-1:0]    dout_re,
   output logic [LANES*O_WIDTH-1:0]    dout_im,
   output logic                        out_last,
   output logic signed [EXP_WIDTH-1:0] exp_out,
   output logic                        ovf
);

   localparam int W  = int_width(I_WIDTH, CNT_WIDTH, LENGTH);
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [BW-1:0]               beat;
   logic [CNT_WIDTH-1:0]        f_shift;
   logic signed [EXP_WIDTH-1:0] f_exp;
   logic                        f_rnd;
   logic                        f_sat;

   logic                        first;
   logic                        last;
   logic [CNT_WIDTH-1:0]        e_shift;
   logic signed [EXP_WIDTH-1:0] e_exp;
   logic                        e_rnd;
   logic                        e_sat;

   // Beat 0 uses the live inputs; later beats use what beat 0 latched.
   assign first   = (beat == '0);
   assign last    = (beat == BW'(BEATS-1));
   assign e_shift = first ? shift_cnt : f_shift;
   assign e_exp   = first ? exp_in    : f_exp;
   assign e_rnd   = first ? rnd_en    : f_rnd;
   assign e_sat   = first ? sat_en    : f_sat;

   logic                        s1_valid;
   logic                        s1_first;
   logic                        s1_last;
   logic                        s1_sat;
   logic signed [EXP_WIDTH-1:0] s1_exp;
   logic signed [W-1:0]         s1_re   [LANES];
   logic signed [W-1:0]         s1_im   [LANES];
   logic signed [W-1:0]         wide_re [LANES];
   logic signed [W-1:0]         wide_im [LANES];
   logic [LANES*O_WIDTH-1:0]    nxt_re;
   logic [LANES*O_WIDTH-1:0]    nxt_im;
   logic [LANES-1:0]            lane_ovf;

   logic s2_ready;
   logic accept;

   assign s2_ready = ~out_valid | out_ready;
   assign in_ready = ~s1_valid | s2_ready;
   assign accept   = in_valid & in_ready;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      bfp_lane_scale #(
         .I_WIDTH   (I_WIDTH),
         .O_WIDTH   (O_WIDTH),
         .CNT_WIDTH (CNT_WIDTH),
         .LENGTH    (LENGTH)
      ) u_lane (
         .rnd_en    (e_rnd),
         .shift_cnt (e_shift),
         .din_re    (din_re[l*I_WIDTH +: I_WIDTH]),
         .din_im    (din_im[l*I_WIDTH +: I_WIDTH]),
         .wide_re   (wide_re[l]),
         .wide_im   (wide_im[l]),
         .sat_en    (s1_sat),
         .s1_re     (s1_re[l]),
         .s1_im     (s1_im[l]),
         .dout_re   (nxt_re[l*O_WIDTH +: O_WIDTH]),
         .dout_im   (nxt_im[l*O_WIDTH +: O_WIDTH]),
         .ovf       (lane_ovf[l])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat      <= '0;
         f_shift   <= '0;
         f_exp     <= '0;
         f_rnd     <= 1'b0;
         f_sat     <= 1'b0;
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_sat    <= 1'b0;
         s1_exp    <= '0;
         for (int l = 0; l < LANES; l++) begin
            s1_re[l] <= '0;
            s1_im[l] <= '0;
         end
         out_valid <= 1'b0;
         dout_re   <= '0;
         dout_im   <= '0;
         out_last  <= 1'b0;
         exp_out   <= '0;
         ovf       <= 1'b0;
      end else begin
         if (accept) begin
            beat <= last ? '0 : beat + BW'(1);
            if (first) begin
               f_shift <= shift_cnt;
               f_exp   <= exp_in;
               f_rnd   <= rnd_en;
               f_sat   <= sat_en;
            end
         end
         if (in_ready) begin
            s1_valid <= accept;
            if (accept) begin
               s1_first <= first;
               s1_last  <= last;
               s1_sat   <= e_sat;
               s1_exp   <= e_exp + EXP_WIDTH'(LENGTH) - EXP_WIDTH'(e_shift);
               for (int l = 0; l < LANES; l++) begin
                  s1_re[l] <= wide_re[l];
                  s1_im[l] <= wide_im[l];
               end
            end
         end
         if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               dout_re  <= nxt_re;
               dout_im  <= nxt_im;
               out_last <= s1_last;
               exp_out  <= s1_exp;
               // The first beat of a frame restarts the sticky flag, so nothing leaks across frames.
               ovf      <= (s1_first ? 1'b0 : ovf) | (|lane_ovf);
            end
         end
      end
   end

endmodule

// File: tb/tb_bfp_rescale.sv
// tb/tb_bfp_rescale.sv - directed self-checking bench for bfp_rescale
module tb_bfp_rescale;

   localparam int LANES     = 16;
   localparam int I_WIDTH   = 23;
   localparam int O_WIDTH   = 11;
   localparam int CNT_WIDTH = 5;
   localparam int LENGTH    = 12;
   localparam int EXP_WIDTH = 6;
   localparam int BEATS     = 32;

   logic                        clk = 1'b0;
   logic                        rstn = 1'b0;
   logic                        in_valid = 1'b0;
   logic                        in_ready;
   logic [LANES*I_WIDTH-1:0]    din_re = '0;
   logic [LANES*I_WIDTH-1:0]    din_im = '0;
   logic [CNT_WIDTH-1:0]        shift_cnt = '0;
   logic signed [EXP_WIDTH-1:0] exp_in = '0;
   logic                        rnd_en = 1'b0;
   logic                        sat_en = 1'b0;
   logic                        out_valid;
   logic                        out_ready = 1'b1;
   logic [LANES*O_WIDTH-1:0]    dout_re;
   logic [LANES*O_WIDTH-1:0]    dout_im;
   logic                        out_last;
   logic signed [EXP_WIDTH-1:0] exp_out;
   logic                        ovf;

   always #5 clk = ~clk;

   bfp_rescale #(
      .LANES(LANES), .I_WIDTH(I_WIDTH), .O_WIDTH(O_WIDTH), .CNT_WIDTH(CNT_WIDTH),
      .LENGTH(LENGTH), .EXP_WIDTH(EXP_WIDTH), .BEATS(BEATS)
   ) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .din_re(din_re), .din_im(din_im), .shift_cnt(shift_cnt), .exp_in(exp_in),
      .rnd_en(rnd_en), .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
      .dout_re(dout_re), .dout_im(dout_im), .out_last(out_last), .exp_out(exp_out), .ovf(ovf)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [CNT_WIDTH-1:0]        f_sc   [2];
   logic signed [EXP_WIDTH-1:0] f_ex   [2];
   logic signed [EXP_WIDTH-1:0] f_eexp [2];
   logic                        f_rnd  [2];
   logic                        f_sat  [2];
   logic                        f_eovf [2];
   int                          f_re   [2];
   int                          f_im   [2];
   int                          f_ere  [2];
   int                          f_eim  [2];

   function automatic logic [LANES*I_WIDTH-1:0] rep_in(input int v);
      logic [LANES*I_WIDTH-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*I_WIDTH +: I_WIDTH] = I_WIDTH'(v);
      return r;
   endfunction

   function automatic logic [LANES*O_WIDTH-1:0] rep_out(input int v);
      logic [LANES*O_WIDTH-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*O_WIDTH +: O_WIDTH] = O_WIDTH'(v);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_frame(input int i, input int sc, input int ex, input int rnd, input int sat,
                            input int re, input int im, input int ere, input int eim,
                            input int eexp, input int eovf);
      f_sc[i]   = CNT_WIDTH'(sc);
      f_ex[i]   = EXP_WIDTH'(ex);
      f_rnd[i]  = rnd[0];
      f_sat[i]  = sat[0];
      f_re[i]   = re;
      f_im[i]   = im;
      f_ere[i]  = ere;
      f_eim[i]  = eim;
      f_eexp[i] = EXP_WIDTH'(eexp);
      f_eovf[i] = eovf[0];
   endtask

   task automatic drive_beat(input int b, input int re, input int im, input int f);
      in_valid = 1'b1;
      din_re   = rep_in(re);
      din_im   = rep_in(im);
      if (b == 0) begin
         shift_cnt = f_sc[f];
         exp_in    = f_ex[f];
         rnd_en    = f_rnd[f];
         sat_en    = f_sat[f];
      end else begin
         shift_cnt = CNT_WIDTH'($urandom);
         exp_in    = EXP_WIDTH'($urandom);
         rnd_en    = 1'($urandom);
         sat_en    = 1'($urandom);
      end
   endtask

   // Back-to-back frames at full rate; non-first beats carry random frame controls.
   task automatic stream(input int nf);
      int nb, j, f, b;
      nb = nf * BEATS;
      for (int k = 0; k < nb + 2; k++) begin
         @(negedge clk);
         if (k == 1) chk("latency", {255'd0, out_valid}, 256'd0);
         if (k >= 2) begin
            j = k - 2;
            f = j / BEATS;
            b = j % BEATS;
            chk($sformatf("valid[%0d]", j), {255'd0, out_valid}, 256'd1);
            chk($sformatf("dout_re[%0d]", j), dout_re, rep_out(f_ere[f]));
            chk($sformatf("dout_im[%0d]", j), dout_im, rep_out(f_eim[f]));
            chk($sformatf("exp_out[%0d]", j), exp_out, f_eexp[f]);
            chk($sformatf("out_last[%0d]", j), {255'd0, out_last}, {255'd0, b == BEATS-1});
            if (b == BEATS-1) chk($sformatf("ovf[%0d]", j), {255'd0, ovf}, {255'd0, f_eovf[f]});
         end
         if (k < nb) drive_beat(k % BEATS, f_re[k / BEATS], f_im[k / BEATS], k / BEATS);
         else in_valid = 1'b0;
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"}, {255'd0, in_ready}, 256'd1);
      chk({tag, "_out_valid"}, {255'd0, out_valid}, 256'd0);
      chk({tag, "_dout_re"}, dout_re, 256'd0);
      chk({tag, "_dout_im"}, dout_im, 256'd0);
      chk({tag, "_out_last"}, {255'd0, out_last}, 256'd0);
      chk({tag, "_ovf"}, {255'd0, ovf}, 256'd0);
      chk({tag, "_exp_out"}, {250'd0, exp_out}, 256'd0);
   endtask

   int ns, nr;
   logic prev_stall;
   logic [LANES*O_WIDTH-1:0] prev_re;
   logic prev_last;

   initial begin
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rstn = 1'b1;

      set_frame(0, 12, 5, 0, 1, 1000, -1000, 1000, -1000, 5, 0);       stream(1);
      set_frame(0, 9, -3, 1, 1, -13, 13, -2, 2, 0, 0);                 stream(1);
      set_frame(0, 9, 10, 0, 1, -13, 13, -2, 1, 13, 0);                stream(1);
      set_frame(0, 14, 0, 0, 1, 600, -600, 1023, -1024, -2, 1);        stream(1);
      set_frame(0, 14, 31, 0, 0, 600, -600, 352, -352, 29, 1);         stream(1);
      set_frame(0, 0, 30, 1, 1, 43008, -43008, 11, -10, -22, 0);       stream(1);
      set_frame(0, 12, -32, 0, 1, 1023, -1024, 1023, -1024, -32, 0);   stream(1);
      set_frame(0, 31, 0, 0, 0, 1, -1, 0, 0, -19, 1);                  stream(1);

      set_frame(0, 12, 0, 0, 1, 1024, 0, 1023, 0, 0, 1);
      set_frame(1, 12, 1, 0, 1, -1024, 5, -1024, 5, 1, 0);             stream(2);
      set_frame(0, 13, 0, 0, 1, 100, -100, 200, -200, -1, 0);
      set_frame(1, 11, 4, 1, 1, 7, -7, 4, -3, 5, 0);                   stream(2);

      // Backpressure: identity shift, per-beat data so loss or duplication is visible.
      set_frame(0, 12, 7, 0, 1, 0, 0, 0, 0, 7, 0);
      ns = 0;
      nr = 0;
      prev_stall = 1'b0;
      prev_re = '0;
      prev_last = 1'b0;
      for (int cyc = 0; cyc < 400 && nr < BEATS; cyc++) begin
         @(negedge clk);
         if (prev_stall) begin
            chk("stall_valid", {255'd0, out_valid}, 256'd1);
            chk("stall_re", dout_re, prev_re);
            chk("stall_last", {255'd0, out_last}, {255'd0, prev_last});
         end
         if (out_valid) begin
            chk($sformatf("bp_re[%0d]", nr), dout_re, rep_out(3 * nr - 40));
            chk($sformatf("bp_im[%0d]", nr), dout_im, rep_out(-nr));
            chk($sformatf("bp_last[%0d]", nr), {255'd0, out_last}, {255'd0, nr == BEATS-1});
            chk($sformatf("bp_exp[%0d]", nr), exp_out, f_eexp[0]);
         end
         out_ready = (cyc >= 20 && cyc < 30) ? 1'b0 : 1'($urandom);
         if (ns < BEATS) drive_beat(ns, 3 * ns - 40, -ns, 0);
         else in_valid = 1'b0;
         #1;
         if (cyc >= 24 && cyc < 30) chk("full_in_ready", {255'd0, in_ready}, 256'd0);
         prev_stall = out_valid & ~out_ready;
         prev_re    = dout_re;
         prev_last  = out_last;
         if (out_valid && out_ready) nr++;
         if (in_valid && in_ready) ns++;
      end
      chk("bp_count", 256'(nr), 256'(BEATS));
      out_ready = 1'b1;
      in_valid  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset partway into a frame, then confirm counting restarts at beat 0.
      set_frame(0, 14, 3, 0, 1, 600, -600, 0, 0, 0, 0);
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         drive_beat(k, 600, -600, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rstn = 1'b0;
      #1;
      check_reset_values("midreset");
      @(negedge clk);
      rstn = 1'b1;
      set_frame(0, 12, 2, 0, 1, 77, -77, 77, -77, 2, 0);               stream(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
